// File: rtl/ex_mem_flag_stage.sv
// EX->MEM pipeline stage: holds the NZCV flag register, resolves B.cond / CBZ / B,
// and registers the ALU result plus memory/writeback controls for the MEM stage.
module ex_mem_flag_stage #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_negative,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic              alu_carry_out,
  input  logic              ex_valid,
  input  logic              ex_set_flags,
  input  logic              ex_cond_br,
  input  logic              ex_cbz,
  input  logic              ex_uncond_br,
  input  logic [3:0]        ex_cond,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              stall,
  input  logic              flush,
  output logic [3:0]        flags_q,
  output logic              mem_valid,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_br_taken,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [4:0]        mem_rd
);

  // Pipeline control: an EX instruction commits only when valid, not stalled and
  // not flushed. The EX/MEM register advances when unstalled or flushed (flush wins
  // over stall and inserts a bubble); flags_q only ever changes on a committing
  // flag-setting instruction.
  logic commit;
  logic load_stage;
  logic cond_true;
  logic taken;
  logic flag_n, flag_z, flag_c, flag_v;

  assign commit     = ex_valid & ~stall & ~flush;
  assign load_stage = flush | ~stall;
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // B.cond always reads the architectural (registered) flags
  always_comb begin
    cond_true = 1'b0;
    case (ex_cond)
      4'b0000: cond_true = flag_z;
      4'b0001: cond_true = ~flag_z;
      4'b0010: cond_true = flag_c;
      4'b0011: cond_true = ~flag_c;
      4'b0100: cond_true = flag_n;
      4'b0101: cond_true = ~flag_n;
      4'b0110: cond_true = flag_v;
      4'b0111: cond_true = ~flag_v;
      4'b1000: cond_true = flag_c & ~flag_z;
      4'b1001: cond_true = ~flag_c | flag_z;
      4'b1010: cond_true = (flag_n == flag_v);
      4'b1011: cond_true = (flag_n != flag_v);
      4'b1100: cond_true = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_true = flag_z | (flag_n != flag_v);
      default: cond_true = 1'b1;
    endcase
  end

  // CBZ relies on the ALU passing Rt through, so alu_zero means Rt == 0
  assign taken = ex_uncond_br | (ex_cond_br & cond_true) | (ex_cbz & alu_zero);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q        <= 4'b0000;
      mem_valid      <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_br_taken   <= 1'b0;
      mem_result     <= '0;
      mem_store_data <= '0;
      mem_rd         <= 5'd0;
    end else begin
      if (commit && ex_set_flags) begin
        flags_q <= {alu_negative, alu_zero, alu_carry_out, alu_overflow};
      end
      if (load_stage) begin
        mem_valid      <= commit;
        mem_reg_write  <= ex_reg_write & commit;
        mem_mem_read   <= ex_mem_read & commit;
        mem_mem_write  <= ex_mem_write & commit;
        mem_br_taken   <= taken & commit;
        mem_result     <= alu_result;
        mem_store_data <= ex_store_data;
        mem_rd         <= ex_rd;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Bench for ex_mem_flag_stage: directed scenarios, a cond x flags sweep and random
// traffic, all checked against an instruction-level reference model.
module tb_ex_mem_flag_stage;
  localparam int W = 64;

  logic clk = 1'b0;
  logic reset;
  logic [W-1:0] alu_result, ex_store_data;
  logic alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic ex_valid, ex_set_flags, ex_cond_br, ex_cbz, ex_uncond_br;
  logic [3:0] ex_cond;
  logic [4:0] ex_rd;
  logic ex_reg_write, ex_mem_read, ex_mem_write, stall, flush;
  logic [3:0] flags_q;
  logic mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_br_taken;
  logic [W-1:0] mem_result, mem_store_data;
  logic [4:0] mem_rd;

  ex_mem_flag_stage #(.DATA_W(W)) dut (
    .clk(clk), .reset(reset),
    .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
    .ex_valid(ex_valid), .ex_set_flags(ex_set_flags), .ex_cond_br(ex_cond_br),
    .ex_cbz(ex_cbz), .ex_uncond_br(ex_uncond_br), .ex_cond(ex_cond), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data), .stall(stall), .flush(flush),
    .flags_q(flags_q), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_br_taken(mem_br_taken), .mem_result(mem_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [3:0]   flags;
    logic         valid, rw, mr, mw, br;
    logic [W-1:0] res, sd;
    logic [4:0]   rd;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;
  int checks = 0;
  int errors = 0;

  function automatic exp_t zero_state();
    exp_t z;
    z.flags = 4'b0; z.valid = 1'b0; z.rw = 1'b0; z.mr = 1'b0; z.mw = 1'b0; z.br = 1'b0;
    z.res = '0; z.sd = '0; z.rd = 5'd0;
    return z;
  endfunction

  // ARM condition semantics: pairs share a base test, odd codes invert it, 1111 is AL
  function automatic logic cond_ref(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, r;
    {n, z, c, v} = f;
    case (cond[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (cond[0] && cond != 4'hF) r = !r;
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_state(input string tag, input exp_t e);
    check({tag, ".flags"}, W'(flags_q), W'(e.flags));
    check({tag, ".valid"}, W'(mem_valid), W'(e.valid));
    check({tag, ".reg_write"}, W'(mem_reg_write), W'(e.rw));
    check({tag, ".mem_read"}, W'(mem_mem_read), W'(e.mr));
    check({tag, ".mem_write"}, W'(mem_mem_write), W'(e.mw));
    check({tag, ".br_taken"}, W'(mem_br_taken), W'(e.br));
    check({tag, ".result"}, mem_result, e.res);
    check({tag, ".store_data"}, mem_store_data, e.sd);
    check({tag, ".rd"}, W'(mem_rd), W'(e.rd));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    alu_result = '0; alu_negative = 0; alu_zero = 0; alu_overflow = 0; alu_carry_out = 0;
    ex_valid = 0; ex_set_flags = 0; ex_cond_br = 0; ex_cbz = 0; ex_uncond_br = 0;
    ex_cond = 4'h0; ex_rd = 5'd0; ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0;
    ex_store_data = '0; stall = 0; flush = 0;
  endtask

  // Drive the ALU outputs for a + b (sub=0) or a - b (sub=1) from wide arithmetic
  task automatic drive_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   s;
    bb = sub ? ~b : b;
    s = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
    alu_result    = s[W-1:0];
    alu_carry_out = s[W];
    alu_negative  = s[W-1];
    alu_zero      = (s[W-1:0] == '0);
    alu_overflow  = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
  endtask

  task automatic drive_random_misc();
    ex_rd = 5'($urandom_range(0, 31));
    ex_reg_write = 1'($urandom); ex_mem_read = 1'($urandom); ex_mem_write = 1'($urandom);
    ex_store_data = {32'($urandom), 32'($urandom)};
  endtask

  // Apply the current inputs for one clock; model the expected register contents
  task automatic step(input string tag);
    logic commit, taken;
    exp_t e;
    taken  = ex_uncond_br || (ex_cond_br && cond_ref(ex_cond, m.flags)) || (ex_cbz && alu_zero);
    commit = ex_valid && !stall && !flush;
    if (commit && ex_set_flags) m.flags = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
    if (flush || !stall) begin
      m.valid = commit;
      m.rw = ex_reg_write && commit;
      m.mr = ex_mem_read && commit;
      m.mw = ex_mem_write && commit;
      m.br = taken && commit;
      m.res = alu_result;
      m.sd = ex_store_data;
      m.rd = ex_rd;
    end
    exp_q.push_back(m);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check_state(tag, e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] saved_flags;
    int k;

    set_idle();
    reset = 1'b1;
    m = zero_state();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_state("reset_init", zero_state());
    reset = 1'b0;

    // SUBS 5-7 then B.LT / B.GE
    set_idle(); drive_random_misc();
    ex_valid = 1; ex_set_flags = 1; drive_alu(64'd5, 64'd7, 1'b1);
    step("subs");
    check("subs.flags_literal", W'(flags_q), W'(4'b1000));
    set_idle(); ex_valid = 1; ex_cond_br = 1; ex_cond = 4'b1011;
    step("b_lt");
    check("b_lt.taken_literal", W'(mem_br_taken), W'(1'b1));
    ex_cond = 4'b1010;
    step("b_ge");
    check("b_ge.taken_literal", W'(mem_br_taken), W'(1'b0));

    // Signed overflow: 0x7FFF...F + 1 -> N=1 V=1
    set_idle(); ex_valid = 1; ex_set_flags = 1;
    drive_alu(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    step("adds_ovf");
    check("adds_ovf.flags_literal", W'(flags_q), W'(4'b1001));
    set_idle(); ex_valid = 1; ex_cond_br = 1;
    ex_cond = 4'b1100; step("b_gt");
    check("b_gt.taken_literal", W'(mem_br_taken), W'(1'b1));
    ex_cond = 4'b1101; step("b_le");
    check("b_le.taken_literal", W'(mem_br_taken), W'(1'b0));
    ex_cond = 4'b0110; step("b_vs");
    check("b_vs.taken_literal", W'(mem_br_taken), W'(1'b1));

    // CBZ: ALU passes Rt through
    saved_flags = m.flags;
    set_idle(); ex_valid = 1; ex_cbz = 1; drive_alu(64'd0, 64'd0, 1'b0);
    step("cbz_zero");
    check("cbz_zero.taken_literal", W'(mem_br_taken), W'(1'b1));
    check("cbz_zero.flags_kept", W'(flags_q), W'(saved_flags));
    drive_alu(64'h10, 64'd0, 1'b0);
    step("cbz_nonzero");
    check("cbz_nonzero.taken_literal", W'(mem_br_taken), W'(1'b0));

    // Stall holding a flag-setting instruction for 3 cycles
    set_idle(); ex_valid = 1; ex_reg_write = 1; ex_rd = 5'd9; drive_alu(64'd3, 64'd4, 1'b0);
    step("pre_stall");
    saved_flags = m.flags;
    ex_set_flags = 1; stall = 1; drive_alu(64'd1, 64'd1, 1'b1);
    ex_rd = 5'd17; ex_store_data = 64'hDEAD;
    for (int i = 0; i < 3; i++) step("stall_hold");
    check("stall.flags_kept", W'(flags_q), W'(saved_flags));
    check("stall.rd_kept", W'(mem_rd), W'(5'd9));

    // Stall and flush together: bubble wins, flags untouched
    flush = 1; ex_uncond_br = 1; ex_set_flags = 0; ex_mem_write = 1;
    step("stall_flush");
    check("stall_flush.valid_literal", W'(mem_valid), W'(1'b0));
    check("stall_flush.flags_kept", W'(flags_q), W'(saved_flags));

    // Sweep every condition against every flag state
    for (int f = 0; f < 16; f++) begin
      set_idle(); ex_valid = 1; ex_set_flags = 1;
      {alu_negative, alu_zero, alu_carry_out, alu_overflow} = 4'(f);
      step("sweep_set");
      for (int c = 0; c < 16; c++) begin
        set_idle(); ex_valid = 1; ex_cond_br = 1; ex_cond = 4'(c);
        step("sweep_bcond");
      end
    end

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      set_idle(); drive_random_misc();
      ex_valid = ($urandom_range(0, 5) != 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = !stall && ($urandom_range(0, 6) == 0);
      ex_cond = 4'($urandom_range(0, 15));
      k = $urandom_range(0, 3);
      if (k == 2) begin
        ex_cbz = 1;
        drive_alu(($urandom_range(0, 1) == 0) ? 64'd0 : {32'($urandom), 32'($urandom)}, 64'd0, 1'b0);
      end else begin
        if ($urandom_range(0, 2) == 0)
          drive_alu(64'($urandom_range(0, 8)), 64'($urandom_range(0, 8)), 1'($urandom));
        else
          drive_alu({32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)}, 1'($urandom));
        ex_cond_br = (k == 1);
        ex_uncond_br = (k == 3);
        ex_set_flags = (k != 1) && 1'($urandom);
      end
      step("random");
    end

    // Asynchronous reset in the middle of a cycle
    set_idle(); drive_random_misc(); ex_valid = 1; ex_set_flags = 1; ex_uncond_br = 1;
    drive_alu(64'd2, 64'd9, 1'b1);
    step("pre_reset");
    #2 reset = 1'b1;
    #1;
    m = zero_state();
    check_state("reset_async", m);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_state("reset_hold", m);
    reset = 1'b0;
    set_idle(); ex_valid = 1; ex_reg_write = 1; ex_rd = 5'd4; drive_alu(64'd1, 64'd2, 1'b0);
    step("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
